mem_req_ctrl: RTL and testbench

MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

---
 rtl/mem_req_ctrl.sv | 157 +++++++++++++++
 tb/tb_mem_req_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
`default_nettype none
//============================================================================
// Module      : mem_req_ctrl
// Description : Burst request controller that turns read/write burst requests
//               into single-port memory accesses. Write bursts follow the
//               incoming write-data stream and stall on gaps. Read bursts
//               issue one read per cycle and return data one cycle later.
//               Optional build macro MEM_REQ_CTRL_WRAP_EN lets bursts wrap
//               past the top address. Without it, such requests are rejected
//               with a req_err pulse.
// Revision    : 1.0 - initial release
//============================================================================
module mem_req_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [LEN_WIDTH-1:0]  req_len,
   input  logic                  wdata_valid,
   output logic                  wdata_ready,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  rdata_valid,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  done,
   output logic                  req_err,
   output logic                  busy,
   output logic                  mem_en,
   output logic                  mem_wr_rd,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   input  logic [DATA_WIDTH-1:0] mem_rd_data
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_READ  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
   logic [LEN_WIDTH-1:0]  r_len, w_len_nxt;
   logic [LEN_WIDTH-1:0]  r_cnt, w_cnt_nxt;
   logic                  r_done, w_done_nxt;
   logic                  r_err, w_err_nxt;
   logic                  r_rvalid, w_rvalid_nxt;
   logic                  w_oob;

`ifdef MEM_REQ_CTRL_WRAP_EN
   // Bursts simply roll over the top of memory, so nothing is out of range.
   assign w_oob = 1'b0;
`else
   localparam int c_SUM_W = ADDR_WIDTH + LEN_WIDTH + 1;
   logic [c_SUM_W-1:0] w_end;

   // Last address of the burst; any bit above the address range means overrun.
   assign w_end = c_SUM_W'(req_addr) + c_SUM_W'(req_len);
   assign w_oob = |w_end[c_SUM_W-1:ADDR_WIDTH];
`endif

   assign req_ready   = (r_state == S_IDLE);
   assign busy        = (r_state != S_IDLE);
   assign rdata_valid = r_rvalid;
   assign rdata       = r_rvalid ? mem_rd_data : '0;
   assign req_err     = r_err;
   // Write completion is registered; read completion is the drain cycle itself.
   assign done        = r_done | (r_state == S_DRAIN);

   // State, burst context and status pulse registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_addr   <= '0;
         r_len    <= '0;
         r_cnt    <= '0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_rvalid <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_addr   <= w_addr_nxt;
         r_len    <= w_len_nxt;
         r_cnt    <= w_cnt_nxt;
         r_done   <= w_done_nxt;
         r_err    <= w_err_nxt;
         r_rvalid <= w_rvalid_nxt;
      end
   end

   // Next-state, burst bookkeeping and memory-side outputs.
   always_comb begin
      w_state_nxt  = r_state;
      w_addr_nxt   = r_addr;
      w_len_nxt    = r_len;
      w_cnt_nxt    = r_cnt;
      w_done_nxt   = 1'b0;
      w_err_nxt    = 1'b0;
      w_rvalid_nxt = 1'b0;
      wdata_ready  = 1'b0;
      mem_en       = 1'b0;
      mem_wr_rd    = 1'b0;
      mem_addr     = '0;
      mem_wr_data  = '0;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               if (w_oob) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_addr_nxt  = req_addr;
                  w_len_nxt   = req_len;
                  w_cnt_nxt   = '0;
                  w_state_nxt = req_wr ? S_WRITE : S_READ;
               end
            end
         end
         S_WRITE: begin
            wdata_ready = 1'b1;
            mem_addr    = r_addr;
            mem_wr_data = wdata;
            if (wdata_valid) begin
               mem_en     = 1'b1;
               mem_wr_rd  = 1'b1;
               w_addr_nxt = r_addr + ADDR_WIDTH'(1);
               w_cnt_nxt  = r_cnt + LEN_WIDTH'(1);
               if (r_cnt == r_len) begin
                  w_state_nxt = S_IDLE;
                  w_done_nxt  = 1'b1;
               end
            end
         end
         S_READ: begin
            mem_en       = 1'b1;
            mem_addr     = r_addr;
            w_rvalid_nxt = 1'b1;
            w_addr_nxt   = r_addr + ADDR_WIDTH'(1);
            w_cnt_nxt    = r_cnt + LEN_WIDTH'(1);
            if (r_cnt == r_len) begin
               w_state_nxt = S_DRAIN;
            end
         end
         default: begin
            // S_DRAIN: last read data is on rdata this cycle.
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_req_ctrl.sv
`default_nettype none
//============================================================================
// Module      : tb_mem_req_ctrl
// Description : Self-checking bench for mem_req_ctrl. Provides the memory,
//               a reference memory image and expected-access queues.
// Revision    : 1.0 - initial release
//============================================================================
module tb_mem_req_ctrl;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_wr;
   logic [9:0]  req_addr;
   logic [7:0]  req_len;
   logic        wdata_valid;
   logic        wdata_ready;
   logic [31:0] wdata;
   logic        rdata_valid;
   logic [31:0] rdata;
   logic        done;
   logic        req_err;
   logic        busy;
   logic        mem_en;
   logic        mem_wr_rd;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wr_data;
   logic [31:0] mem_rd_data;

   mem_req_ctrl #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(10),
      .LEN_WIDTH (8)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wr     (req_wr),
      .req_addr   (req_addr),
      .req_len    (req_len),
      .wdata_valid(wdata_valid),
      .wdata_ready(wdata_ready),
      .wdata      (wdata),
      .rdata_valid(rdata_valid),
      .rdata      (rdata),
      .done       (done),
      .req_err    (req_err),
      .busy       (busy),
      .mem_en     (mem_en),
      .mem_wr_rd  (mem_wr_rd),
      .mem_addr   (mem_addr),
      .mem_wr_data(mem_wr_data),
      .mem_rd_data(mem_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory attached to the DUT: one-cycle read latency.
   logic [31:0] ram [1024] = '{default: 32'h0};
   always @(posedge clk) begin
      if (mem_en && mem_wr_rd) ram[mem_addr] <= mem_wr_data;
      if (mem_en && !mem_wr_rd) mem_rd_data <= ram[mem_addr];
   end

   // Reference model: expected memory image and expected access / read streams.
   typedef struct packed {
      logic        wr;
      logic [9:0]  addr;
      logic [31:0] data;
   } acc_t;

   logic [31:0] ref_mem [1024] = '{default: 32'h0};
   acc_t        exp_acc[$];
   logic [31:0] exp_rd[$];
   int          n_err  = 0;
   int          n_chk  = 0;
   int          n_done = 0;
   int          n_rej  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int t;
      t = 0;
      while (!req_ready && t < 50) begin
         tick();
         t++;
      end
      if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic wr_burst(input logic [9:0] a, input logic [7:0] len, input logic [31:0] base,
                           input int stall_at, input int stall_n, input bit expect_ok);
      logic [9:0] ai;
      wait_ready();
      if (expect_ok) begin
         for (int i = 0; i <= int'(len); i++) begin
            ai = a + 10'(i);
            exp_acc.push_back('{wr: 1'b1, addr: ai, data: base + 32'(i)});
            ref_mem[ai] = base + 32'(i);
         end
      end
      req_valid = 1'b1;
      req_wr    = 1'b1;
      req_addr  = a;
      req_len   = len;
      tick();
      req_valid = 1'b0;
      if (!expect_ok) begin
         chk("rej_err_pulse", 32'(req_err), 32'd1);
         chk("rej_stays_idle", 32'(busy), 32'd0);
         tick();
         chk("rej_err_one_cycle", 32'(req_err), 32'd0);
         return;
      end
      for (int i = 0; i <= int'(len); i++) begin
         if (i == stall_at) begin
            for (int s = 0; s < stall_n; s++) begin
               wdata_valid = 1'b0;
               req_valid   = 1'b1;
               #1;
               chk("stall_no_mem_en", 32'(mem_en), 32'd0);
               chk("busy_holdoff_ready", 32'(req_ready), 32'd0);
               tick();
            end
            req_valid = 1'b0;
         end
         wdata_valid = 1'b1;
         wdata       = base + 32'(i);
         tick();
      end
      wdata_valid = 1'b0;
      chk("wr_done_after_last", 32'(done), 32'd1);
      chk("wr_idle_after_last", 32'(busy), 32'd0);
      tick();
      chk("wr_done_one_cycle", 32'(done), 32'd0);
   endtask

   task automatic rd_burst(input logic [9:0] a, input logic [7:0] len, output logic [31:0] last);
      logic [9:0] ai;
      int rv;
      int dn;
      wait_ready();
      for (int i = 0; i <= int'(len); i++) begin
         ai = a + 10'(i);
         exp_acc.push_back('{wr: 1'b0, addr: ai, data: 32'h0});
         exp_rd.push_back(ref_mem[ai]);
      end
      req_valid = 1'b1;
      req_wr    = 1'b0;
      req_addr  = a;
      req_len   = len;
      tick();
      req_valid = 1'b0;
      rv   = 0;
      dn   = 0;
      last = 32'h0;
      for (int c = 0; c < int'(len) + 4; c++) begin
         @(negedge clk);
         if (rdata_valid) rv++;
         if (done) begin
            dn++;
            chk("rd_done_with_rvalid", 32'(rdata_valid), 32'd1);
            chk("rd_done_on_last_beat", 32'(rv), 32'(len) + 32'd1);
            last = rdata;
         end
      end
      chk("rd_done_once", 32'(dn), 32'd1);
      chk("rd_beat_count", 32'(rv), 32'(len) + 32'd1);
      @(posedge clk);
      #1;
   endtask

   // Per-cycle compare against the reference model.
   initial begin
      acc_t a;
      logic [31:0] d;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("ready_is_not_busy", 32'(req_ready), 32'(!busy));
            chk("done_err_exclusive", 32'(done & req_err), 32'd0);
            if (done) n_done++;
            if (req_err) n_rej++;
            if (!busy) begin
               chk("idle_mem_en", 32'(mem_en), 32'd0);
               chk("idle_mem_wr_rd", 32'(mem_wr_rd), 32'd0);
               chk("idle_mem_addr", 32'(mem_addr), 32'd0);
               chk("idle_mem_wr_data", mem_wr_data, 32'd0);
               chk("idle_wdata_ready", 32'(wdata_ready), 32'd0);
            end
            if (mem_en) begin
               if (exp_acc.size() == 0) begin
                  chk("unexpected_mem_en", 32'd1, 32'd0);
               end else begin
                  a = exp_acc.pop_front();
                  chk("acc_dir", 32'(mem_wr_rd), 32'(a.wr));
                  chk("acc_addr", 32'(mem_addr), 32'(a.addr));
                  if (a.wr) chk("acc_wdata", mem_wr_data, a.data);
               end
            end
            if (rdata_valid) begin
               if (exp_rd.size() == 0) begin
                  chk("unexpected_rdata_valid", 32'd1, 32'd0);
               end else begin
                  d = exp_rd.pop_front();
                  chk("rdata", rdata, d);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1);
   end

   // Directed stimulus.
   initial begin
      logic [31:0] last;
      int d0;
      int r0;
      rst         = 1'b0;
      req_valid   = 1'b0;
      req_wr      = 1'b0;
      req_addr    = '0;
      req_len     = '0;
      wdata_valid = 1'b0;
      wdata       = '0;
      tick();
      tick();
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
      rst = 1'b1;
      tick();

      // Continuous write then read-back.
      wr_burst(10'h010, 8'd3, 32'hA0, -1, 0, 1'b1);
      chk("ram_0x013_literal", ram[10'h013], 32'hA3);
      rd_burst(10'h010, 8'd3, last);
      chk("rd_last_literal_A3", last, 32'hA3);

      // Write with a two-cycle data gap, plus hold-off of a new request.
      wr_burst(10'h040, 8'd5, 32'hC0, 2, 2, 1'b1);
      chk("ram_0x042_literal", ram[10'h042], 32'hC2);
      rd_burst(10'h040, 8'd5, last);
      chk("rd_last_literal_C5", last, 32'hC5);

      // Single-beat bursts.
      wr_burst(10'h100, 8'd0, 32'h55, -1, 0, 1'b1);
      rd_burst(10'h100, 8'd0, last);
      chk("rd_single_literal", last, 32'h55);

      // Write data outside a write burst is ignored.
      wdata_valid = 1'b1;
      wdata       = 32'hDEAD;
      #1;
      chk("idle_wdata_ignored_ready", 32'(wdata_ready), 32'd0);
      chk("idle_wdata_ignored_en", 32'(mem_en), 32'd0);
      tick();
      tick();
      wdata_valid = 1'b0;

      // Burst crossing the top address.
      d0 = n_done;
      r0 = n_rej;
`ifdef MEM_REQ_CTRL_WRAP_EN
      wr_burst(10'h3FE, 8'd3, 32'hB0, -1, 0, 1'b1);
      chk("wrap_ram_0x3FF", ram[10'h3FF], 32'hB1);
      chk("wrap_ram_0x001", ram[10'h001], 32'hB3);
      rd_burst(10'h3FE, 8'd3, last);
      chk("wrap_rd_last", last, 32'hB3);
`else
      wr_burst(10'h3FE, 8'd3, 32'hB0, -1, 0, 1'b0);
      tick();
      chk("rej_no_done", 32'(n_done - d0), 32'd0);
      chk("rej_one_err_pulse", 32'(n_rej - r0), 32'd1);
      chk("rej_ram_untouched", ram[10'h3FE], 32'h0);
`endif

      // Reset during the second beat of an eight-beat read.
      wait_ready();
      for (int i = 0; i < 8; i++) begin
         exp_acc.push_back('{wr: 1'b0, addr: 10'h010 + 10'(i), data: 32'h0});
         exp_rd.push_back(ref_mem[10'h010 + 10'(i)]);
      end
      req_valid = 1'b1;
      req_wr    = 1'b0;
      req_addr  = 10'h010;
      req_len   = 8'd7;
      tick();
      req_valid = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      chk("mrst_mem_en", 32'(mem_en), 32'd0);
      chk("mrst_mem_wr_rd", 32'(mem_wr_rd), 32'd0);
      chk("mrst_mem_addr", 32'(mem_addr), 32'd0);
      chk("mrst_mem_wr_data", mem_wr_data, 32'd0);
      chk("mrst_rdata_valid", 32'(rdata_valid), 32'd0);
      chk("mrst_rdata", rdata, 32'd0);
      chk("mrst_done", 32'(done), 32'd0);
      chk("mrst_req_err", 32'(req_err), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_wdata_ready", 32'(wdata_ready), 32'd0);
      chk("mrst_req_ready", 32'(req_ready), 32'd1);
      exp_acc.delete();
      exp_rd.delete();
      d0 = n_done;
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("mrst_no_done", 32'(n_done - d0), 32'd0);
      rd_burst(10'h010, 8'd3, last);
      chk("post_rst_rd_literal", last, 32'hA3);

      tick();
      chk("acc_queue_drained", 32'(exp_acc.size()), 32'd0);
      chk("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
